// File: rtl/ring_slot_tracker.sv
// Slot tracker for a 32-slot one-hot ring: decodes the active slot, counts rotations,
// offers one-hot grants with a valid/ready handshake and keeps sticky error flags.
// Optional sequence checking is compiled in when RING_SEQ_CHECK_EN is defined.
module ring_slot_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ring_q,
  input  logic [31:0]      req,
  input  logic             err_clr,
  input  logic             grant_ready,
  output logic [4:0]       slot_idx,
  output logic             slot_valid,
  output logic [31:0]      grant,
  output logic             grant_valid,
  output logic [CNT_W-1:0] rot_count,
  output logic             err_onehot,
  output logic             err_seq
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state_q, state_d;
  logic [4:0]         slot_idx_q, slot_idx_d;
  logic               slot_valid_q, slot_valid_d;
  logic [31:0]        grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0]   rot_q, rot_d;
  logic               err_onehot_q, err_onehot_d;

  logic               onehot;
  logic               req_hit;
  logic [4:0]         enc_idx;

  // Mask of slot positions whose index has bit b set; OR-reducing ring_q against it
  // yields bit b of the encoded index when ring_q is one-hot.
  function automatic logic [31:0] bit_mask(input int b);
    logic [31:0] m;
    for (int k = 0; k < 32; k++) begin
      m[k] = (((k >> b) & 1) == 1);
    end
    return m;
  endfunction

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_enc
      assign enc_idx[gi] = |(ring_q & bit_mask(gi));
    end
  endgenerate

  assign onehot  = (ring_q != 32'd0) && ((ring_q & (ring_q - 32'd1)) == 32'd0);
  assign req_hit = onehot && ((ring_q & req) != 32'd0);

  always_comb begin
    state_d       = state_q;
    slot_idx_d    = slot_idx_q;
    slot_valid_d  = 1'b0;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    rot_d         = rot_q;

    if (onehot) begin
      slot_idx_d   = enc_idx;
      slot_valid_d = 1'b1;
      if (slot_valid_q && (slot_idx_q == 5'd31) && (enc_idx == 5'd0)) begin
        rot_d = rot_q + 1'b1;
      end
    end

    // Set has priority over clear.
    if (!onehot)      err_onehot_d = 1'b1;
    else if (err_clr) err_onehot_d = 1'b0;
    else              err_onehot_d = err_onehot_q;

    case (state_q)
      IDLE: begin
        if (req_hit) begin
          state_d       = OFFER;
          grant_d       = ring_q;
          grant_valid_d = 1'b1;
        end
      end
      OFFER: begin
        if (grant_ready) begin
          state_d       = IDLE;
          grant_d       = 32'd0;
          grant_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = 32'd0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_idx_q    <= 5'd0;
      slot_valid_q  <= 1'b0;
      grant_q       <= 32'd0;
      grant_valid_q <= 1'b0;
      rot_q         <= '0;
      err_onehot_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_idx_q    <= slot_idx_d;
      slot_valid_q  <= slot_valid_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      rot_q         <= rot_d;
      err_onehot_q  <= err_onehot_d;
    end
  end

`ifdef RING_SEQ_CHECK_EN
  logic err_seq_q, err_seq_d;
  logic seq_bad;

  // Only two consecutive valid slots can be compared; the 5-bit add wraps 31 -> 0.
  assign seq_bad = onehot && slot_valid_q && (enc_idx != (slot_idx_q + 5'd1));

  always_comb begin
    if (seq_bad)      err_seq_d = 1'b1;
    else if (err_clr) err_seq_d = 1'b0;
    else              err_seq_d = err_seq_q;
  end

  always_ff @(posedge clk) begin
    if (reset) err_seq_q <= 1'b0;
    else       err_seq_q <= err_seq_d;
  end

  assign err_seq = err_seq_q;
`else
  assign err_seq = 1'b0;
`endif

  assign slot_idx    = slot_idx_q;
  assign slot_valid  = slot_valid_q;
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign rot_count   = rot_q;
  assign err_onehot  = err_onehot_q;

endmodule

// File: tb/tb_ring_slot_tracker.sv
// Self-checking bench for ring_slot_tracker: directed vector table, hand-written
// scenarios and randomized traffic checked against a behavioural slot/grant model.
module tb_ring_slot_tracker;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      ring_q = '0;
  logic [31:0]      req = '0;
  logic             err_clr = 1'b0;
  logic             grant_ready = 1'b0;
  logic [4:0]       slot_idx;
  logic             slot_valid;
  logic [31:0]      grant;
  logic             grant_valid;
  logic [CNT_W-1:0] rot_count;
  logic             err_onehot;
  logic             err_seq;

  int n_cmp = 0;
  int n_fail = 0;

  ring_slot_tracker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ring_q(ring_q), .req(req), .err_clr(err_clr),
    .grant_ready(grant_ready), .slot_idx(slot_idx), .slot_valid(slot_valid),
    .grant(grant), .grant_valid(grant_valid), .rot_count(rot_count),
    .err_onehot(err_onehot), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  // Behavioural reference: slot number, whether the last sample was a legal slot,
  // the pending offer and the error/rotation bookkeeping.
  int          m_slot;
  bit          m_valid;
  bit          m_offer;
  int          m_gslot;
  int          m_rot;
  bit          m_eo;
  bit          m_es;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [31:0] rg, input logic [31:0] rq,
                            input bit gr, input bit clr);
    int  cnt;
    int  k;
    bit  seq_bad;
    if (r) begin
      m_slot = 0; m_valid = 0; m_offer = 0; m_gslot = 0;
      m_rot = 0; m_eo = 0; m_es = 0;
      return;
    end
    cnt = $countones(rg);
    k = 0;
    for (int i = 0; i < 32; i++) if (rg[i]) k = i;
    seq_bad = 0;
    if (m_offer) begin
      if (gr) m_offer = 0;
    end else if (cnt == 1 && rq[k]) begin
      m_offer = 1;
      m_gslot = k;
    end
    if (cnt == 1) begin
      if (m_valid && m_slot == 31 && k == 0) m_rot = (m_rot + 1) % (1 << CNT_W);
`ifdef RING_SEQ_CHECK_EN
      if (m_valid && k != (m_slot + 1) % 32) seq_bad = 1;
`endif
      m_slot = k;
    end
    if (cnt != 1) m_eo = 1;
    else if (clr) m_eo = 0;
    if (seq_bad) m_es = 1;
    else if (clr) m_es = 0;
    m_valid = (cnt == 1);
  endtask

  task automatic step(input bit r, input logic [31:0] rg, input logic [31:0] rq,
                      input bit gr, input bit clr);
    logic [31:0] exp_grant;
    reset = r; ring_q = rg; req = rq; grant_ready = gr; err_clr = clr;
    @(posedge clk);
    model_edge(r, rg, rq, gr, clr);
    #1;
    exp_grant = m_offer ? (32'd1 << m_gslot) : 32'd0;
    chk("slot_idx",    32'(slot_idx),    32'(m_slot));
    chk("slot_valid",  32'(slot_valid),  32'(m_valid));
    chk("grant",       grant,            exp_grant);
    chk("grant_valid", 32'(grant_valid), 32'(m_offer));
    chk("rot_count",   32'(rot_count),   32'(m_rot));
    chk("err_onehot",  32'(err_onehot),  32'(m_eo));
    chk("err_seq",     32'(err_seq),     32'(m_es));
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] ring;
    logic [31:0] rq;
    bit          gr;
    bit          clr;
    logic [4:0]  e_idx;
    bit          e_valid;
    logic [31:0] e_grant;
    bit          e_gv;
    bit          e_eo;
  } vec_t;

  vec_t vt[14];

  initial begin
    int pos;
    int sel;
    logic [31:0] rg;

    // rst ring rq gr clr | idx valid grant gv eo
    vt[0]  = '{1, 32'h0,   32'h0,        0, 0, 5'd0, 0, 32'h0,   0, 0};
    vt[1]  = '{0, 32'h1,   32'h0,        0, 0, 5'd0, 1, 32'h0,   0, 0};
    vt[2]  = '{0, 32'h2,   32'h2,        0, 0, 5'd1, 1, 32'h2,   1, 0};
    vt[3]  = '{0, 32'h4,   32'h4,        0, 0, 5'd2, 1, 32'h2,   1, 0};
    vt[4]  = '{0, 32'h8,   32'h0,        1, 0, 5'd3, 1, 32'h0,   0, 0};
    vt[5]  = '{0, 32'h6,   32'hFFFFFFFF, 0, 0, 5'd3, 0, 32'h0,   0, 1};
    vt[6]  = '{0, 32'h0,   32'h0,        0, 0, 5'd3, 0, 32'h0,   0, 1};
    vt[7]  = '{0, 32'h10,  32'h0,        0, 1, 5'd4, 1, 32'h0,   0, 0};
    vt[8]  = '{0, 32'h20,  32'h0,        1, 0, 5'd5, 1, 32'h0,   0, 0};
    vt[9]  = '{0, 32'h40,  32'h40,       0, 1, 5'd6, 1, 32'h40,  1, 0};
    vt[10] = '{0, 32'h0,   32'h0,        0, 1, 5'd6, 0, 32'h40,  1, 1};
    vt[11] = '{0, 32'h80,  32'h0,        1, 0, 5'd7, 1, 32'h0,   0, 1};
    vt[12] = '{0, 32'h100, 32'h100,      1, 0, 5'd8, 1, 32'h100, 1, 1};
    vt[13] = '{1, 32'h200, 32'h200,      0, 0, 5'd0, 0, 32'h0,   0, 0};

    for (int i = 0; i < 14; i++) begin
      step(vt[i].rst, vt[i].ring, vt[i].rq, vt[i].gr, vt[i].clr);
      chk($sformatf("vec%0d.idx", i),   32'(slot_idx),    32'(vt[i].e_idx));
      chk($sformatf("vec%0d.valid", i), 32'(slot_valid),  32'(vt[i].e_valid));
      chk($sformatf("vec%0d.grant", i), grant,            vt[i].e_grant);
      chk($sformatf("vec%0d.gv", i),    32'(grant_valid), 32'(vt[i].e_gv));
      chk($sformatf("vec%0d.eo", i),    32'(err_onehot),  32'(vt[i].e_eo));
      $display("vec %0d ring=0x%0h idx=%0d valid=%0d grant=0x%0h", i, vt[i].ring,
               slot_idx, slot_valid, grant);
    end

    // One full rotation and back to slot 0 counts exactly once.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i <= 32; i++) step(0, 32'd1 << (i % 32), 0, 0, 0);
    chk("rot1.count", 32'(rot_count), 32'd1);
    chk("rot1.idx",   32'(slot_idx),  32'd0);
    chk("rot1.eo",    32'(err_onehot), 32'd0);
    $display("scenario rotation: rot_count=%0d", rot_count);

    // Offer on slot 3 held for four cycles while the consumer stalls.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 32'd1 << i, 32'h8, 0, 0);
    for (int i = 4; i < 7; i++) begin
      chk("hold.grant_pre", grant, 32'h8);
      step(0, 32'd1 << i, 32'h8, 0, 0);
    end
    chk("hold.grant_last", grant, 32'h8);
    chk("hold.gv_last",    32'(grant_valid), 32'd1);
    step(0, 32'h80, 32'h8, 1, 0);
    chk("hold.grant_done", grant, 32'h0);
    chk("hold.gv_done",    32'(grant_valid), 32'd0);
    $display("scenario stall: grant=0x%0h gv=%0d", grant, grant_valid);

    // Slot 4 missed while slot 3 is offered; the next slot-3 pass regrants.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 32'd1 << i, 32'h18, 0, 0);
    chk("miss.grant", grant, 32'h8);
    step(0, 32'h20, 32'h18, 1, 0);
    chk("miss.cleared", 32'(grant_valid), 32'd0);
    for (int i = 6; i <= 35; i++) step(0, 32'd1 << (i % 32), 32'h18, 0, 0);
    chk("miss.regrant", grant, 32'h8);
    $display("scenario miss: grant=0x%0h", grant);

    // Sixteen rotations with a 4-bit counter wrap it to zero.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i <= 16 * 32; i++) step(0, 32'd1 << (i % 32), 0, 0, 0);
    chk("wrap.count", 32'(rot_count), 32'd0);
    $display("scenario wrap: rot_count=%0d", rot_count);

    // Reset while an offer is pending abandons it.
    step(0, 32'h2, 32'h2, 0, 0);
    chk("rstoffer.pre", 32'(grant_valid), 32'd1);
    step(1, 32'h4, 32'h4, 0, 0);
    chk("rstoffer.grant", grant, 32'h0);
    chk("rstoffer.gv",    32'(grant_valid), 32'd0);

    // Skipped slot 0x1 -> 0x4.
    step(1, 0, 0, 0, 0);
    step(0, 32'h1, 0, 0, 0);
    step(0, 32'h4, 0, 0, 0);
`ifdef RING_SEQ_CHECK_EN
    chk("seq.flag", 32'(err_seq), 32'd1);
`else
    chk("seq.flag", 32'(err_seq), 32'd0);
`endif
    $display("scenario skip: err_seq=%0d", err_seq);

    // Randomized traffic, mostly legal rotation with injected faults.
    pos = 0;
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(99);
      if (sel < 88) begin
        rg = 32'd1 << pos; pos = (pos + 1) % 32;
      end else if (sel < 92) begin
        rg = $urandom;
      end else if (sel < 96) begin
        pos = (pos + 2) % 32; rg = 32'd1 << pos;
      end else begin
        rg = 32'd0;
      end
      step(($urandom_range(199) == 0), rg, $urandom & $urandom,
           ($urandom_range(2) == 0), ($urandom_range(9) == 0));
    end
    $display("random: done, rot_count=%0d", rot_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_slot_tracker.md
RING_SLOT_TRACKER -- requirements
Module: ring_slot_tracker

Interface
REQ-001 Parameter CNT_W, default 16: width of the rotation counter.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port ring_q  input  32  one-hot slot vector from the upstream ring counter; bit k active means slot k.
REQ-005 Port req  input  32  per-slot service request; req[k] is sampled only while slot k is active.
REQ-006 Port err_clr  input  1  clears the sticky error flags.
REQ-007 Port grant_ready  input  1  consumer accepts the offered grant.
REQ-008 Port slot_idx  output  5  binary index of the last valid slot.
REQ-009 Port slot_valid  output  1  ring_q was exactly one-hot on the previous edge.
REQ-010 Port grant  output  32  one-hot granted slot; all zeros when no grant is offered.
REQ-011 Port grant_valid  output  1  grant offer is pending.
REQ-012 Port rot_count  output  CNT_W  count of completed ring rotations.
REQ-013 Port err_onehot  output  1  sticky flag: ring_q was seen with zero or more than one bit set.
REQ-014 Port err_seq  output  1  sticky flag: the ring did not step by exactly one slot.

Function
REQ-015 All outputs SHALL be registered with 1-cycle latency: inputs sampled at edge N appear after edge N.
REQ-016 If popcount(ring_q) == 1: slot_valid SHALL be 1 and slot_idx SHALL be the encoded index.
REQ-017 If popcount(ring_q) != 1 (including 0): slot_valid SHALL be 0, slot_idx SHALL hold its value, and err_onehot SHALL set.
REQ-018 rot_count SHALL increment by 1 on an edge where the new index is 0 and the held index is 31, with both valid.
REQ-019 rot_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-020 The grant FSM SHALL have two states, IDLE and OFFER; the reset state is IDLE.
REQ-021 IDLE -> OFFER on an edge where ring_q is one-hot with index k and req[k]=1; on that edge grant loads onehot(k) and grant_valid loads 1.
REQ-022 In OFFER, grant and grant_valid SHALL stay stable until grant_valid && grant_ready.
REQ-023 On handshake (grant_valid && grant_ready), grant SHALL clear to 0, grant_valid to 0, and the FSM returns to IDLE; a new offer can start no earlier than the following edge.
REQ-024 Requests arriving while in OFFER SHALL be ignored (slot missed); slot tracking continues unaffected.
REQ-025 grant_ready while in IDLE SHALL have no effect.
REQ-026 An invalid ring_q SHALL never create a grant.
REQ-027 err_clr SHALL clear both sticky flags; if a set condition and err_clr occur on the same edge, set wins.

Reset
REQ-028 While reset=1 at an edge: slot_idx=0, slot_valid=0, grant=0, grant_valid=0, rot_count=0, err_onehot=0, err_seq=0, FSM=IDLE, and the previous-valid tracker is cleared.
REQ-029 Reset asserted during OFFER SHALL abandon the offer without a handshake.
REQ-030 On the first edge after reset, any one-hot ring_q SHALL be accepted with no err_seq check.

Configuration
REQ-031 Macro RING_SEQ_CHECK_EN SHALL enable sequence checking.
REQ-032 When defined: on an edge where both the held and the new slot are valid, err_seq SHALL set if new index != (held index + 1) mod 32.
REQ-033 When undefined: err_seq SHALL be constant 0 and no sequence-check logic is instantiated.

Verification
REQ-034 Scenario 1: reset, then ring_q rotates 1, 2, 4, ..., 2^31, 1 -> slot_idx 0..31 then 0, slot_valid=1, rot_count=1, no errors.
REQ-035 Scenario 2: req=0x0000_0008, grant_ready=0 until 3 cycles after the offer -> grant=0x0000_0008 and grant_valid=1 held stable for 4 cycles, then both 0.
REQ-036 Scenario 3: req=0x0000_0018, grant_ready=0 -> slot 3 is granted and slot 4 is missed with the grant unchanged; then grant_ready=1 -> IDLE, and the next slot-3 pass grants again.
REQ-037 Scenario 4: ring_q=0x0000_0006 for 1 cycle -> slot_valid=0, slot_idx held, err_onehot=1 sticky; then err_clr=1 -> err_onehot=0.
REQ-038 Scenario 5 (macro defined): ring_q steps 0x1 to 0x4 -> err_seq=1; the same stimulus with the macro undefined -> err_seq=0.
REQ-039 Scenario 6: with CNT_W=4, run 16 rotations -> rot_count wraps to 0; reset asserted mid-offer -> all outputs 0 on the next cycle.
